mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port of the multicycle core between the instruction-fetch
//  requester and the load/store data requester. Each requester uses a req/ack handshake.
//  The block sequences the fixed read latency and the one-cycle write pulse.
//  Fetch and data requests are arbitrated round-robin.
//  Sits between the control-unit/datapath (PC, ALUOut address regs) and the memory.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width
//  RD_LAT  2   memory read latency in cycles (>=1); mem_rdata valid RD_LAT cycles after mem_addr
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous reset, active-low (0 = reset)
//  if_req     in   1       fetch read request; held until if_ack
//  if_addr    in   ADDR_W  fetch address
//  if_ack     out  1       one-cycle pulse; if_rdata valid from this cycle
//  if_rdata   out  DATA_W  fetched word, held until next fetch ack
//  d_req      in   1       data request; held until d_ack
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       one-cycle pulse; completes read or write
//  d_rdata    out  DATA_W  loaded word, held until next data read ack
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_wdata  out  DATA_W  memory write data (registered)
//  mem_wr     out  1       memory write strobe
//  mem_rdata  in   DATA_W  memory read data
//  grant      out  2       00 none, 01 fetch, 10 data (owner of current transaction)
//  estado     out  2       current FSM state, for debug/waveforms
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; every output 0; last_owner = DATA, so fetch wins first.
//  States: IDLE(0), ACCESS(1), DONE(2).
//  IDLE, no req: stay.
//  IDLE, any req: pick winner.
//   - Single req: that one wins.
//   - Both: the port that is not last_owner wins.
//   - At the edge: latch addr, wdata, we (fetch is always we=0) and owner into mem_addr/mem_wdata.
//   - At the edge: update last_owner, load cnt = RD_LAT-1 (read) or 0 (write), go ACCESS.
//  ACCESS:
//   - grant = owner; mem_wr = latched we.
//   - cnt>0: decrement.
//   - cnt==0: on a read, capture mem_rdata into the owner's rdata register; go DONE.
//   - Write therefore strobes mem_wr for exactly 1 cycle.
//  DONE: owner's ack = 1 for this cycle only; grant still = owner; mem_wr = 0; go IDLE.
//  Latency from req seen in IDLE to ack: read RD_LAT+2 cycles, write 3 cycles.
//  Requester drops req at the edge ending DONE. Req still high in the following IDLE = new request.
//  Req deasserted or d_we/addr changed mid-transaction: ignored; transaction completes and acks.
//  New requests during ACCESS/DONE: not sampled until IDLE; no request is lost while held.
//  Reset mid-transaction: abort immediately. mem_wr drops asynchronously; no ack after release.
//  The aborted requester must re-request.
//  mem_addr/mem_wdata hold last latched value in IDLE. The other port's rdata is untouched.
//  cnt width = $clog2(RD_LAT+1). RD_LAT=1 gives a single ACCESS cycle.
//  No ack is ever issued to a non-owner. if_ack and d_ack are never high together.
// STRUCTURE
//  Package mem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t
//   - grant encodings GNT_NONE/GNT_IF/GNT_D
//   - owner_t {OWN_IF, OWN_D}
//  Sub-module arb_rr2:
//   - Combinational 2-way round-robin picker.
//   - Inputs: req[1:0], last_owner. Output: winner.
//  Top: one always_ff for state, cnt, latches and rdata regs; one always_comb for outputs.
// TESTING (RD_LAT=2 unless noted)
//  1. Hold reset=0, toggle clk.
//     -> all outputs 0, estado=0. Release, no reqs -> stays IDLE, grant=00.
//  2. if_req, if_addr=0x10; memory returns 0xDEADBEEF.
//     -> mem_addr=0x10, grant=01 for 3 cycles; if_ack pulses 4 cycles after req sampled.
//     -> if_rdata=0xDEADBEEF; d_ack never.
//  3. d_req, d_we=1, d_addr=0x40, d_wdata=0x1234.
//     -> mem_wr=1 exactly one cycle with mem_addr=0x40, mem_wdata=0x1234; d_ack 3 cycles after req.
//  4. if_req and d_req both held high from reset.
//     -> grant order IF, D, IF, D; each ack is a single pulse; req held after ack is re-served.
//  5. Data read addr 0x80 at RD_LAT=1, mem_rdata=0xCAFE0001.
//     -> d_ack 3 cycles after req, d_rdata=0xCAFE0001, if_rdata unchanged.
//  6. reset=0 during ACCESS of a write.
//     -> mem_wr drops same cycle; after release estado=IDLE, no d_ack; re-req completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, owner ids, grant codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    function automatic logic [1:0] owner_to_grant(input owner_t o);
        return (o == OWN_D) ? GNT_D : GNT_IF;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: req[0] is fetch, req[1] is data; on a tie the
// requester that did not own the previous transaction wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     winner
);

    always_comb begin
        winner = OWN_IF;
        if (req[0] && req[1]) begin
            winner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (req[1]) begin
            winner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, sequencing the
// fixed read latency and the single-cycle write strobe with round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic [1:0]        estado
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    owner_t            winner;

    arb_rr2 u_rr (
        .req        ({d_req, if_req}),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_D;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d      = winner;
                    last_owner_d = winner;
                    if (winner == OWN_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                    end
                    // Writes need only one ACCESS cycle; reads wait out the memory latency.
                    cnt_d   = we_d ? '0 : CNT_W'(RD_LAT - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        if (owner_q == OWN_D) d_rdata_d  = mem_rdata;
                        else                  if_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant  = GNT_NONE;
        mem_wr = 1'b0;
        if_ack = 1'b0;
        d_ack  = 1'b0;
        case (state_q)
            ACCESS: begin
                grant  = owner_to_grant(owner_q);
                mem_wr = we_q;
            end
            DONE: begin
                grant  = owner_to_grant(owner_q);
                if_ack = (owner_q == OWN_IF);
                d_ack  = (owner_q == OWN_D);
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign estado    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=2 instance for most scenarios,
// RD_LAT=1 instance for the short-latency data read.
module tb_mem_port_arbiter;

    logic clk;
    int   tests = 0;
    int   fails = 0;

    logic        rst_n, if_req, if_ack, d_req, d_we, d_ack, mem_wr;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant, estado;

    logic        b_rst_n, b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_wr;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_grant, b_estado;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut (
        .clk(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .grant(grant), .estado(estado)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_b (
        .clk(clk), .reset(b_rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr), .mem_rdata(b_mem_rdata),
        .grant(b_grant), .estado(b_estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = JUNK;
        b_rst_n = 1'b0; b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = JUNK;

        // 1: reset state
        step(); step();
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_b_estado", 32'(b_estado), 32'd0);
        rst_n = 1'b1; b_rst_n = 1'b1;
        step();
        chk("idle_estado", 32'(estado), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);

        // 5: RD_LAT=1 instance, fetch first so if_rdata has a known value
        b_if_req = 1'b1; b_if_addr = 32'h20;
        step();
        chk("b_f_estado", 32'(b_estado), 32'd1);
        chk("b_f_grant", 32'(b_grant), 32'd1);
        b_mem_rdata = 32'h1111_2222;
        step();
        b_mem_rdata = JUNK; b_if_req = 1'b0;
        chk("b_f_ack", 32'(b_if_ack), 32'd1);
        chk("b_f_rdata", b_if_rdata, 32'h1111_2222);
        step();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h80;
        step();
        chk("b_d_grant", 32'(b_grant), 32'd2);
        chk("b_d_addr", b_mem_addr, 32'h80);
        chk("b_d_ack_early", 32'(b_d_ack), 32'd0);
        b_mem_rdata = 32'hCAFE_0001;
        step();
        b_mem_rdata = JUNK; b_d_req = 1'b0;
        chk("b_d_ack", 32'(b_d_ack), 32'd1);
        chk("b_d_rdata", b_d_rdata, 32'hCAFE_0001);
        chk("b_if_rdata_kept", b_if_rdata, 32'h1111_2222);
        step();
        chk("b_d_ack_drop", 32'(b_d_ack), 32'd0);
        chk("b_idle", 32'(b_estado), 32'd0);

        // 2: fetch read, RD_LAT=2
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_grant1", 32'(grant), 32'd1);
        chk("f_ack1", 32'(if_ack), 32'd0);
        step();
        chk("f_grant2", 32'(grant), 32'd1);
        chk("f_ack2", 32'(if_ack), 32'd0);
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rdata = JUNK; if_req = 1'b0;
        chk("f_grant3", 32'(grant), 32'd1);
        chk("f_ack3", 32'(if_ack), 32'd1);
        chk("f_d_ack", 32'(d_ack), 32'd0);
        chk("f_rdata", if_rdata, 32'hDEAD_BEEF);
        step();
        chk("f_ack_drop", 32'(if_ack), 32'd0);
        chk("f_grant_idle", 32'(grant), 32'd0);
        chk("f_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // 3: data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        step();
        d_addr = 32'h99; d_wdata = 32'h9999;
        chk("w_mem_wr", 32'(mem_wr), 32'd1);
        chk("w_mem_addr", mem_addr, 32'h40);
        chk("w_mem_wdata", mem_wdata, 32'h1234);
        chk("w_grant", 32'(grant), 32'd2);
        step();
        d_req = 1'b0;
        chk("w_mem_wr_off", 32'(mem_wr), 32'd0);
        chk("w_d_ack", 32'(d_ack), 32'd1);
        chk("w_if_ack", 32'(if_ack), 32'd0);
        step();
        chk("w_d_ack_drop", 32'(d_ack), 32'd0);
        chk("w_addr_hold", mem_addr, 32'h40);
        chk("w_d_rdata", d_rdata, 32'd0);

        // 4: both requesters held from reset -> IF, D, IF, D
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic is_if;
            logic [31:0] val;
            is_if = (i % 2 == 0);
            val = 32'hA000_0000 + 32'(i);
            step();
            chk("rr_grant", 32'(grant), is_if ? 32'd1 : 32'd2);
            chk("rr_addr", mem_addr, is_if ? 32'h100 : 32'h200);
            step();
            mem_rdata = val;
            step();
            mem_rdata = JUNK;
            chk("rr_if_ack", 32'(if_ack), is_if ? 32'd1 : 32'd0);
            chk("rr_d_ack", 32'(d_ack), is_if ? 32'd0 : 32'd1);
            chk("rr_rdata", is_if ? if_rdata : d_rdata, val);
            step();
            chk("rr_idle_acks", 32'({if_ack, d_ack}), 32'd0);
            chk("rr_idle_grant", 32'(grant), 32'd0);
        end

        // 6: reset during ACCESS of a write
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h5678;
        step();
        chk("ab_mem_wr", 32'(mem_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ab_mem_wr_async", 32'(mem_wr), 32'd0);
        chk("ab_estado_async", 32'(estado), 32'd0);
        d_req = 1'b0;
        step();
        rst_n = 1'b1;
        chk("ab_rel_estado", 32'(estado), 32'd0);
        step();
        chk("ab_no_ack", 32'(d_ack), 32'd0);
        chk("ab_still_idle", 32'(estado), 32'd0);
        d_req = 1'b1;
        step();
        chk("rq_mem_wr", 32'(mem_wr), 32'd1);
        chk("rq_mem_addr", mem_addr, 32'h44);
        chk("rq_mem_wdata", mem_wdata, 32'h5678);
        step();
        d_req = 1'b0;
        chk("rq_d_ack", 32'(d_ack), 32'd1);
        chk("rq_mem_wr_off", 32'(mem_wr), 32'd0);
        step();
        chk("rq_idle", 32'(estado), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
